// File: rtl/sram_bus_arbiter_pkg.sv
// Shared ids and FSM encodings for the SRAM-like bus arbiter.
package sram_bus_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// In-order FIFO of grant ids for accepted-but-unanswered bus transactions.
module arb_order_fifo #(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          head,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign push_ok = push && (count != (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop_ok)
                rd_ptr <= nxt(rd_ptr);
            if (push_ok && !pop_ok)
                count <= count + (PW+1)'(1);
            else if (pop_ok && !push_ok)
                count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-port to one SRAM-like bus arbiter with in-order response steering.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of data priority.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ID_PW     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_e       state;
    arb_state_e       state_d;
    logic             arb_sel;
    logic             sel;
    logic             sel_req;
    logic             full;
    logic             push;
    logic             pop;
    logic             head;
    logic             empty;
    logic [ID_PW:0]   count;

`ifdef SRAM_ARB_RR_EN
    logic             last_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_grant <= ARB_ID_INST;
        else if (push)
            last_grant <= sel;
    end
`endif

    always_comb begin
        arb_sel = data_req ? ARB_ID_DATA : ARB_ID_INST;
`ifdef SRAM_ARB_RR_EN
        if (data_req && inst_req)
            arb_sel = (last_grant == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
`endif
        unique case (state)
            ARB_LOCK_I: sel = ARB_ID_INST;
            ARB_LOCK_D: sel = ARB_ID_DATA;
            default:    sel = arb_sel;
        endcase
    end

    // no bypass: a pop in the same cycle does not free a slot for a new grant
    assign full    = (count == (ID_PW+1)'(MAX_OUTST));
    assign sel_req = (sel == ARB_ID_DATA) ? data_req : inst_req;
    assign bus_req = resetn && sel_req && !full;
    assign push    = bus_req && bus_addr_ok;
    assign pop     = resetn && bus_data_ok && !empty;

    assign bus_wr    = (sel == ARB_ID_DATA) ? data_wr    : inst_wr;
    assign bus_size  = (sel == ARB_ID_DATA) ? data_size  : inst_size;
    assign bus_addr  = (sel == ARB_ID_DATA) ? data_addr  : inst_addr;
    assign bus_wstrb = (sel == ARB_ID_DATA) ? data_wstrb : 4'b0000;
    assign bus_wdata = (sel == ARB_ID_DATA) ? data_wdata : 32'd0;

    assign inst_addr_ok = push && (sel == ARB_ID_INST);
    assign data_addr_ok = push && (sel == ARB_ID_DATA);
    assign inst_data_ok = pop && (head == ARB_ID_INST);
    assign data_data_ok = pop && (head == ARB_ID_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_comb begin
        state_d = state;
        unique case (state)
            ARB_IDLE:
                if (bus_req && !bus_addr_ok)
                    state_d = (sel == ARB_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
            ARB_LOCK_I, ARB_LOCK_D:
                if (push)
                    state_d = ARB_IDLE;
            default:
                state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ARB_IDLE;
        else
            state <= state_d;
    end

    arb_order_fifo #(
        .DEPTH (MAX_OUTST),
        .PW    (ID_PW)
    ) u_order_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (sel),
        .head   (head),
        .empty  (empty),
        .count  (count)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: vector table, corner sequences, random vs queue model.
module tb_sram_bus_arbiter;

    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // model: owner -1 = free, 0 = inst locked, 1 = data locked
    int owner;
    bit order[$];
    bit last;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .ID_PW(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic i, d, aok, dok;
        logic breq, sel, iaok, daok, idok, ddok;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1000;
        data_req = 0; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h2000; data_wdata = 32'h5555_AAAA;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
        owner = -1;
        order.delete();
        last = 0;
    endtask

    task automatic model_step();
        int  who;
        bit  req_w, e_breq, e_push, e_pop;
        if (owner >= 0)
            who = owner;
        else begin
            who = data_req ? 1 : 0;
`ifdef SRAM_ARB_RR_EN
            if (data_req && inst_req)
                who = last ? 0 : 1;
`endif
        end
        req_w  = who == 1 ? data_req : inst_req;
        e_breq = resetn && req_w && (order.size() < MAX_OUTST);
        e_push = e_breq && bus_addr_ok;
        e_pop  = resetn && bus_data_ok && (order.size() > 0);
        chk("rnd_bus_req", 32'(bus_req), 32'(e_breq));
        chk("rnd_inst_addr_ok", 32'(inst_addr_ok), 32'(e_push && who == 0));
        chk("rnd_data_addr_ok", 32'(data_addr_ok), 32'(e_push && who == 1));
        chk("rnd_inst_data_ok", 32'(inst_data_ok), 32'(e_pop && order[0] == 0));
        chk("rnd_data_data_ok", 32'(data_data_ok), 32'(e_pop && order[0] == 1));
        if (e_breq) begin
            chk("rnd_bus_addr", bus_addr, who == 1 ? data_addr : inst_addr);
            chk("rnd_bus_wr", 32'(bus_wr), 32'(who == 1 ? data_wr : inst_wr));
            chk("rnd_bus_size", 32'(bus_size), 32'(who == 1 ? data_size : inst_size));
            if (who == 1) begin
                chk("rnd_bus_wstrb", 32'(bus_wstrb), 32'(data_wstrb));
                chk("rnd_bus_wdata", bus_wdata, data_wdata);
            end
        end
        if (resetn) begin
            chk("rnd_inst_rdata", inst_rdata, bus_rdata);
            chk("rnd_data_rdata", data_rdata, bus_rdata);
        end
        if (!resetn) begin
            owner = -1;
            order.delete();
            last = 0;
        end else begin
            if (owner < 0 && e_breq && !bus_addr_ok)
                owner = who;
            else if (owner >= 0 && e_push)
                owner = -1;
            if (e_pop)
                void'(order.pop_front());
            if (e_push) begin
                order.push_back(who == 1);
                last = (who == 1);
            end
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        owner = -1;
        last = 0;

        // reset forces handshakes low; release grants inst immediately
        inst_req = 1; bus_addr_ok = 1;
        #1;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        tick();
        resetn = 1;
        #1;
        chk("rel_bus_req", 32'(bus_req), 1);
        chk("rel_bus_addr", bus_addr, 32'h1000);
        tick();

        do_reset();
        tbl[0]  = {4'b1110, 6'b110100};
        tbl[1]  = {4'b1010, 6'b101000};
        tbl[2]  = {4'b0001, 6'b000001};
        tbl[3]  = {4'b0001, 6'b000010};
        tbl[4]  = {4'b0001, 6'b000000};
        tbl[5]  = {4'b1000, 6'b100000};
        tbl[6]  = {4'b1100, 6'b100000};
        tbl[7]  = {4'b1100, 6'b100000};
        tbl[8]  = {4'b1110, 6'b101000};
        tbl[9]  = {4'b0110, 6'b110100};
        tbl[10] = {4'b1010, 6'b000000};
        tbl[11] = {4'b1011, 6'b000010};
        tbl[12] = {4'b1010, 6'b101000};
        tbl[13] = {4'b0001, 6'b000001};
        tbl[14] = {4'b0001, 6'b000010};
        for (int k = 0; k < 15; k++) begin
            inst_req    = tbl[k].i;
            data_req    = tbl[k].d;
            bus_addr_ok = tbl[k].aok;
            bus_data_ok = tbl[k].dok;
            bus_rdata   = 32'hDEADBEEF;
            #1;
            chk($sformatf("v%0d_bus_req", k), 32'(bus_req), 32'(tbl[k].breq));
            chk($sformatf("v%0d_inst_addr_ok", k), 32'(inst_addr_ok), 32'(tbl[k].iaok));
            chk($sformatf("v%0d_data_addr_ok", k), 32'(data_addr_ok), 32'(tbl[k].daok));
            chk($sformatf("v%0d_inst_data_ok", k), 32'(inst_data_ok), 32'(tbl[k].idok));
            chk($sformatf("v%0d_data_data_ok", k), 32'(data_data_ok), 32'(tbl[k].ddok));
            if (tbl[k].breq) begin
                chk($sformatf("v%0d_bus_addr", k), bus_addr,
                    tbl[k].sel ? 32'h2000 : 32'h1000);
                chk($sformatf("v%0d_bus_wr", k), 32'(bus_wr), 32'(tbl[k].sel));
            end
            tick();
        end

        // both requesting continuously with immediate acceptance
        do_reset();
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef SRAM_ARB_RR_EN
            chk("both_data_addr_ok", 32'(data_addr_ok), 32'(k % 2 == 0));
            chk("both_inst_addr_ok", 32'(inst_addr_ok), 32'(k % 2 == 1));
`else
            chk("both_data_addr_ok", 32'(data_addr_ok), 1);
            chk("both_inst_addr_ok", 32'(inst_addr_ok), 0);
`endif
            tick();
        end

        // reset mid-transaction drops the outstanding entry
        do_reset();
        inst_req = 1; bus_addr_ok = 1;
        #1;
        chk("mid_inst_addr_ok", 32'(inst_addr_ok), 1);
        tick();
        inst_req = 0; bus_addr_ok = 0; resetn = 0;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 0);
        tick();
        resetn = 1; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
        #1;
        chk("late_inst_data_ok", 32'(inst_data_ok), 0);
        chk("late_data_data_ok", 32'(data_data_ok), 0);
        tick();

        // random traffic against the queue model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            resetn      = ($urandom_range(0, 59) != 0);
            inst_req    = $urandom_range(0, 2) != 0;
            data_req    = $urandom_range(0, 1) != 0;
            inst_size   = 2'($urandom_range(0, 3));
            inst_addr   = $urandom;
            data_wr     = 1'($urandom_range(0, 1));
            data_size   = 2'($urandom_range(0, 3));
            data_wstrb  = 4'($urandom_range(0, 15));
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_addr_ok = $urandom_range(0, 2) != 0;
            bus_data_ok = $urandom_range(0, 2) == 0;
            bus_rdata   = $urandom;
            #1;
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
